// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the next-PC controller slice.
//   - FSM state encoding (RUN/BUBBLE/HALT)
//   - next-PC select enum
//   - default PC/address width and a bubble-counter load helper
package pc_ctrl_pkg;

  localparam int unsigned PC_AW = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_HOLD
  } pc_sel_t;

  // Bubble counter is 2 bits wide; configurations above 3 saturate.
  function automatic logic [1:0] bubble_load(input int unsigned cyc);
    logic [1:0] v;
    if (cyc > 3) v = 2'd3;
    else         v = cyc[1:0];
    return v;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO), DEPTH x AW.
//   A push while full overwrites the oldest entry; a pop while empty is ignored.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_push, i_data  push i_data onto the stack
//   i_pop           discard the top entry
//   o_top           current top entry (undefined when empty)
//   o_full, o_empty occupancy flags
module pc_ras
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AW    = PC_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [AW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_sp;   // next free slot; equals the oldest slot when full
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] w_top_idx;

  assign w_top_idx = (r_sp == '0) ? LAST : r_sp - 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_sp <= (r_sp == LAST) ? '0 : r_sp + 1'b1;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp  <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_sp] <= i_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 16-bit single-cycle core.
//   Selects the next PC (increment / branch / jump / return / hold), applies
//   stall and halt, and flushes fetch for BUBBLE_CYC cycles after a redirect.
// Configuration macro: PC_RAS_EN (adds return-address stack for call/ret).
//   Undefined: call acts as jmp, ret is ignored, ras_err is tied 0.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   pc_in         current PC register value
//   stall         hold PC this cycle
//   br_taken      conditional branch taken, offset br_ofs (signed)
//   jmp           absolute jump to jmp_addr
//   call, ret     call (push pc_in+1, jump) / return (pop, jump)
//   halt, resume  enter / leave HALT
//   target        next PC value (0 while rst is high)
//   flush         squash the instruction fetched this cycle
//   halted        high while in HALT
//   ras_err       sticky RAS overflow/underflow flag
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AW         = PC_AW,
  parameter int unsigned OFS_W      = 8,
  parameter int unsigned BUBBLE_CYC = 1,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    pc_in,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [OFS_W-1:0] br_ofs,
  input  logic             jmp,
  input  logic [AW-1:0]    jmp_addr,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  input  logic             resume,
  output logic [AW-1:0]    target,
  output logic             flush,
  output logic             halted,
  output logic             ras_err
);

  pc_state_t   r_state, w_state_nxt;
  logic [1:0]  r_bub_cnt, w_bub_cnt_nxt;
  pc_sel_t     w_sel;
  logic        w_flush;
  logic        w_redirect;
  logic        w_push, w_pop, w_err_set;
  logic [AW-1:0] w_inc, w_br, w_mux;

  assign w_inc = pc_in + 1'b1;
  assign w_br  = pc_in + 1'b1 + {{(AW-OFS_W){br_ofs[OFS_W-1]}}, br_ofs};

`ifdef PC_RAS_EN
  logic [AW-1:0] w_ras_top;
  logic          w_ras_full, w_ras_empty;
  logic          r_ras_err;

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ras_err <= 1'b0;
    else if (w_err_set) r_ras_err <= 1'b1;
  end

  assign ras_err = r_ras_err;
`else
  // No RAS: ret has no effect, and the stack depth is irrelevant.
  logic        w_unused_ret;
  logic [31:0] w_unused_ras_depth;
  assign w_unused_ret       = ret;
  assign w_unused_ras_depth = RAS_DEPTH;
  assign ras_err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_bub_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bub_cnt <= w_bub_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bub_cnt_nxt = r_bub_cnt;
    w_sel         = SEL_HOLD;
    w_flush       = 1'b0;
    w_redirect    = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_err_set     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_sel       = SEL_HOLD;
          w_state_nxt = ST_HALT;
`ifdef PC_RAS_EN
        end else if (ret) begin
          // Underflow falls through to a plain increment with no bubble.
          if (w_ras_empty) begin
            w_sel     = SEL_INC;
            w_err_set = 1'b1;
          end else begin
            w_sel      = SEL_RET;
            w_pop      = 1'b1;
            w_redirect = 1'b1;
          end
`endif
        end else if (call) begin
          w_sel      = SEL_JMP;
          w_redirect = 1'b1;
`ifdef PC_RAS_EN
          w_push     = 1'b1;
          w_err_set  = w_ras_full;
`endif
        end else if (jmp) begin
          w_sel      = SEL_JMP;
          w_redirect = 1'b1;
        end else if (br_taken) begin
          w_sel      = SEL_BR;
          w_redirect = 1'b1;
        end else if (stall) begin
          w_sel = SEL_HOLD;
        end else begin
          w_sel = SEL_INC;
        end

        if (w_redirect && (BUBBLE_CYC != 0)) begin
          w_state_nxt   = ST_BUBBLE;
          w_bub_cnt_nxt = bubble_load(BUBBLE_CYC);
        end
      end

      ST_BUBBLE: begin
        w_sel   = SEL_HOLD;
        w_flush = 1'b1;
        if (halt) begin
          w_state_nxt   = ST_HALT;
          w_bub_cnt_nxt = '0;
        end else begin
          w_bub_cnt_nxt = r_bub_cnt - 1'b1;
          if (r_bub_cnt <= 2'd1) w_state_nxt = ST_RUN;
        end
      end

      ST_HALT: begin
        w_sel = SEL_HOLD;
        if (resume && !halt) w_state_nxt = ST_RUN;
      end

      default: begin
        w_state_nxt   = ST_RUN;
        w_bub_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_mux = pc_in;
    case (w_sel)
      SEL_INC:  w_mux = w_inc;
      SEL_BR:   w_mux = w_br;
      SEL_JMP:  w_mux = jmp_addr;
`ifdef PC_RAS_EN
      SEL_RET:  w_mux = w_ras_top;
`else
      SEL_RET:  w_mux = w_inc;
`endif
      default:  w_mux = pc_in;
    endcase
  end

  // Outputs are forced quiet for the whole time reset is held.
  assign target = rst ? '0 : w_mux;
  assign flush  = !rst && w_flush;
  assign halted = !rst && (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int BC    = 1;
  localparam int DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk, rst;
  logic [15:0] pc_in, jmp_addr, target;
  logic [7:0]  br_ofs;
  logic        stall, br_taken, jmp, call, ret, halt, resume;
  logic        flush, halted, ras_err;

  pc_sequencer #(
    .AW         (16),
    .OFS_W      (8),
    .BUBBLE_CYC (BC),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .stall    (stall),
    .br_taken (br_taken),
    .br_ofs   (br_ofs),
    .jmp      (jmp),
    .jmp_addr (jmp_addr),
    .call     (call),
    .ret      (ret),
    .halt     (halt),
    .resume   (resume),
    .target   (target),
    .flush    (flush),
    .halted   (halted),
    .ras_err  (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] pc, input logic st, input logic br,
                        input logic [7:0] ofs, input logic jp, input logic [15:0] ja,
                        input logic cl, input logic rt, input logic hl, input logic rs);
    pc_in = pc; stall = st; br_taken = br; br_ofs = ofs; jmp = jp; jmp_addr = ja;
    call = cl; ret = rt; halt = hl; resume = rs;
  endtask

  // ---------------- reference model ----------------
  // mode: 0 running, 1 flushing after redirect, 2 halted
  int          m_mode;
  int          m_left;
  int          m_stack[$];
  bit          m_err;
  logic [15:0] last_exp, last_tgt;

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_stack.delete(); m_err = 1'b0;
  endtask

  task automatic m_eval(output logic [15:0] et, output bit ef, output bit eh);
    int  o;
    bit  redir;
    int  pc;
    pc    = int'(pc_in);
    o     = int'(br_ofs);
    if (o >= 128) o -= 256;
    redir = 1'b0;
    ef    = 1'b0;
    eh    = 1'b0;
    et    = pc_in;
    if (m_mode == 2) begin
      eh = 1'b1;
      if (resume && !halt) m_mode = 0;
    end else if (m_mode == 1) begin
      ef = 1'b1;
      if (halt) begin m_mode = 2; m_left = 0; end
      else begin
        m_left--;
        if (m_left <= 0) m_mode = 0;
      end
    end else begin
      if (halt) m_mode = 2;
      else if (RAS_ON && ret) begin
        if (m_stack.size() == 0) begin et = 16'(pc + 1); m_err = 1'b1; end
        else begin et = 16'(m_stack.pop_back()); redir = 1'b1; end
      end else if (call) begin
        et = jmp_addr; redir = 1'b1;
        if (RAS_ON) begin
          if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); m_err = 1'b1; end
          m_stack.push_back(pc + 1 & 16'hFFFF);
        end
      end else if (jmp) begin et = jmp_addr; redir = 1'b1; end
      else if (br_taken) begin et = 16'(pc + 1 + o); redir = 1'b1; end
      else if (stall) et = pc_in;
      else et = 16'(pc + 1);
      if (redir && BC > 0) begin m_mode = 1; m_left = BC; end
    end
  endtask

  // Apply inputs, compare against the model mid-cycle, then advance one clock.
  task automatic mstep(input logic [15:0] pc, input logic st, input logic br,
                       input logic [7:0] ofs, input logic jp, input logic [15:0] ja,
                       input logic cl, input logic rt, input logic hl, input logic rs);
    logic [15:0] et;
    bit ef, eh, eerr;
    set_in(pc, st, br, ofs, jp, ja, cl, rt, hl, rs);
    #4;
    eerr = m_err;
    m_eval(et, ef, eh);
    chk("target", target, et);
    chk("flush", flush, ef);
    chk("halted", halted, eh);
    chk("ras_err", ras_err, eerr);
    last_exp = et;
    last_tgt = target;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(16'h0010, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    #3;
    chk("rst_target", target, 16'h0000);
    chk("rst_flush", flush, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ras_err", ras_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] pc; logic st, br; logic [7:0] ofs; logic jp; logic [15:0] ja;
    logic cl, rt, hl, rs;
    logic [15:0] et; logic ef, eh;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] pc, input logic st, input logic br,
                              input logic [7:0] ofs, input logic jp, input logic [15:0] ja,
                              input logic cl, input logic hl, input logic rs,
                              input logic [15:0] et, input logic ef, input logic eh);
    vec_t v;
    v.pc = pc; v.st = st; v.br = br; v.ofs = ofs; v.jp = jp; v.ja = ja;
    v.cl = cl; v.rt = 1'b0; v.hl = hl; v.rs = rs; v.et = et; v.ef = ef; v.eh = eh;
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    tbl[0]  = mk(16'h0010, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0011, 0, 0);
    tbl[1]  = mk(16'hFFFF, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    tbl[2]  = mk(16'h0100, 0, 1, 8'hFC, 0, 16'h0000, 0, 0, 0, 16'h00FD, 0, 0);
    tbl[3]  = mk(16'h00FD, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h00FD, 1, 0);
    tbl[4]  = mk(16'h00FD, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h00FE, 0, 0);
    tbl[5]  = mk(16'h0200, 1, 0, 8'h00, 1, 16'h1234, 0, 0, 0, 16'h1234, 0, 0);
    tbl[6]  = mk(16'h1234, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h1234, 1, 0);
    tbl[7]  = mk(16'h1234, 1, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h1234, 0, 0);
    tbl[8]  = mk(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h0040, 0, 0);
    for (int i = 9; i < 14; i++)
      tbl[i] = mk(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0040, 0, 1);
    tbl[14] = mk(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 1, 16'h0040, 0, 1);
    tbl[15] = mk(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 1, 16'h0040, 0, 1);
    tbl[16] = mk(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0041, 0, 0);
    tbl[17] = mk(16'h0050, 0, 1, 8'h7F, 0, 16'h0000, 0, 0, 0, 16'h00D0, 0, 0);
    tbl[18] = mk(16'h00D0, 0, 0, 8'h00, 1, 16'h9999, 0, 0, 0, 16'h00D0, 1, 0);
    tbl[19] = mk(16'h0300, 0, 0, 8'h00, 0, 16'h0800, 1, 0, 0, 16'h0800, 0, 0);
    tbl[20] = mk(16'h0800, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h0800, 1, 0);
    tbl[21] = mk(16'h0800, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 1, 16'h0800, 0, 1);
    tbl[22] = mk(16'h0800, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0801, 0, 0);
    tbl[23] = mk(16'h0010, 0, 1, 8'h80, 0, 16'h0000, 0, 0, 0, 16'hFF91, 0, 0);
    tbl[24] = mk(16'hFF91, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'hFF91, 1, 0);
    tbl[25] = mk(16'hFF91, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'hFF92, 0, 0);

    rst = 1'b1;
    set_in(16'h0010, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    m_reset();
    #1;
    do_reset();

    foreach (tbl[i]) begin
      set_in(tbl[i].pc, tbl[i].st, tbl[i].br, tbl[i].ofs, tbl[i].jp, tbl[i].ja,
             tbl[i].cl, tbl[i].rt, tbl[i].hl, tbl[i].rs);
      #4;
      chk($sformatf("tbl%0d_target", i), target, tbl[i].et);
      chk($sformatf("tbl%0d_flush", i), flush, tbl[i].ef);
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].eh);
      @(posedge clk); #1;
    end

    // Reset asserted mid-HALT: outputs drop immediately, back in RUN afterwards.
    do_reset();
    mstep(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 1, 0);
    mstep(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midhalt_rst_halted", halted, 1'b0);
    chk("midhalt_rst_target", target, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    mstep(16'h0040, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    chk("after_rst_run", last_tgt, 16'h0041);

    // Reset asserted mid-BUBBLE.
    mstep(16'h0041, 0, 0, 8'h00, 1, 16'h0777, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midbub_rst_flush", flush, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    mstep(16'h0777, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    chk("midbub_after_rst", last_tgt, 16'h0778);

`ifdef PC_RAS_EN
    do_reset();
    mstep(16'h0010, 0, 0, 8'h00, 0, 16'h0800, 1, 0, 0, 0);
    chk("call_target", last_tgt, 16'h0800);
    mstep(16'h0800, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    mstep(16'h0805, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0);
    chk("ret_target", last_tgt, 16'h0011);
    mstep(16'h0011, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      mstep(16'(16'h0100 + i), 0, 0, 8'h00, 0, 16'(16'h0200 + i), 1, 0, 0, 0);
      mstep(16'(16'h0200 + i), 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      mstep(16'(16'h0300 + i), 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0);
      chk("nested_ret", last_tgt, 16'(16'h0105 - i));
      mstep(last_exp, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    end
    mstep(16'h0304, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0);
    chk("underflow_target", last_tgt, 16'h0305);
    mstep(16'h0305, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    chk("underflow_no_bubble", last_tgt, 16'h0306);
    chk("ras_err_sticky", ras_err, 1'b1);
    // call with ret: ret wins (stack empty -> pc+1), push dropped
    do_reset();
    mstep(16'h0020, 0, 0, 8'h00, 0, 16'h0900, 1, 1, 0, 0);
    chk("callret_target", last_tgt, 16'h0021);
`else
    do_reset();
    mstep(16'h0123, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0);
    chk("ret_ignored", last_tgt, 16'h0124);
    mstep(16'h0124, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 0);
    chk("ret_no_bubble", last_tgt, 16'h0125);
    mstep(16'h0125, 0, 0, 8'h00, 0, 16'h0A00, 1, 0, 0, 0);
    chk("call_as_jmp", last_tgt, 16'h0A00);
    chk("ras_err_tied", ras_err, 1'b0);
`endif

    // Randomized run against the model.
    do_reset();
    last_exp = 16'h0010;
    for (int n = 0; n < 600; n++) begin
      logic [15:0] pc;
      if (n % 150 == 149) begin
        do_reset();
        last_exp = 16'h0010;
      end
      pc = ($urandom_range(0, 7) == 0) ? 16'($urandom) : last_exp;
      mstep(pc,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0,
            8'($urandom),
            $urandom_range(0, 9) == 0,
            16'($urandom),
            $urandom_range(0, 9) == 0,
            RAS_ON && ($urandom_range(0, 7) == 0),
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
